// File: rtl/vdec_tb_param_if.sv
// Traceback control, survivor-RAM and decoded-output signal bundle for vdec_tb_param.
// dec_bits exists only when VDEC_TB_PARALLEL_OUT_EN is defined.
interface vdec_tb_param_if #(
  parameter int unsigned STATE_W  = 8,
  parameter int unsigned PT_W     = 32,
  parameter int unsigned MAX_BLK  = 29,
  parameter int unsigned TAIL_LEN = 8
);
  localparam int unsigned LOG_PT = $clog2(PT_W);
  localparam int unsigned WSEL_W = STATE_W - LOG_PT;
  localparam int unsigned STG_W  = $clog2(MAX_BLK + TAIL_LEN);
  localparam int unsigned ADDR_W = STG_W + WSEL_W;
  localparam int unsigned BLK_W  = $clog2(MAX_BLK + 1);

  logic               start;
  logic               abort;
  logic [BLK_W-1:0]   blk_len;
  logic [STATE_W-1:0] start_state;
  logic               busy;
  logic               done;
  logic               pt_rd;
  logic [ADDR_W-1:0]  pt_addr;
  logic [PT_W-1:0]    pt_dout;
  logic               out_valid;
  logic               out_bit;
  logic               out_last;
`ifdef VDEC_TB_PARALLEL_OUT_EN
  logic [MAX_BLK-1:0] dec_bits;
`endif

  modport master (
    output start, abort, blk_len, start_state, pt_dout,
    input  busy, done, pt_rd, pt_addr, out_valid, out_bit, out_last
`ifdef VDEC_TB_PARALLEL_OUT_EN
    , input dec_bits
`endif
  );

  modport slave (
    input  start, abort, blk_len, start_state, pt_dout,
    output busy, done, pt_rd, pt_addr, out_valid, out_bit, out_last
`ifdef VDEC_TB_PARALLEL_OUT_EN
    , output dec_bits
`endif
  );
endinterface

// File: rtl/vdec_tb_param.sv
// Viterbi traceback unit: walks the survivor RAM one stage per cycle and streams decoded bits.
// Optional parallel block output enabled by defining VDEC_TB_PARALLEL_OUT_EN.
module vdec_tb_param #(
  parameter int unsigned STATE_W  = 8,
  parameter int unsigned PT_W     = 32,
  parameter int unsigned MAX_BLK  = 29,
  parameter int unsigned TAIL_LEN = 8
) (
  input logic           clk,
  input logic           rst_n,
  vdec_tb_param_if.slave bus
);
  localparam int unsigned LOG_PT = $clog2(PT_W);
  localparam int unsigned WSEL_W = STATE_W - LOG_PT;
  localparam int unsigned STG_W  = $clog2(MAX_BLK + TAIL_LEN);
  localparam int unsigned ADDR_W = STG_W + WSEL_W;
  localparam int unsigned BLK_W  = $clog2(MAX_BLK + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    TRACE = 2'd1,
    FIN   = 2'd2
  } state_e;

  state_e             state_q;
  logic               busy_q;
  logic               done_q;
  logic               pt_rd_q;
  logic               first_q;
  logic [STG_W-1:0]   stage_q;
  logic               dat_vld_q;
  logic [STG_W-1:0]   dat_stage_q;
  logic [STATE_W-1:0] cur_q;
  logic [BLK_W-1:0]   blk_q;
  logic               out_valid_q;
  logic               out_bit_q;
  logic               out_last_q;
`ifdef VDEC_TB_PARALLEL_OUT_EN
  logic [MAX_BLK-1:0] dec_q;
`endif

  logic [BLK_W-1:0]   blk_sat_c;
  logic [LOG_PT-1:0]  bidx_c;
  logic               surv_c;
  logic [STATE_W-1:0] cur_d;
  logic [WSEL_W-1:0]  wsel_c;
  logic [ADDR_W-1:0]  addr_c;

  // Survivor lookup and predecessor; the next word select follows the freshly read word.
  always_comb begin
    blk_sat_c = (bus.blk_len > BLK_W'(MAX_BLK)) ? BLK_W'(MAX_BLK) : bus.blk_len;
    bidx_c    = ~cur_q[LOG_PT-1:0];
    surv_c    = bus.pt_dout[bidx_c];
    cur_d     = {surv_c, cur_q[STATE_W-1:1]};
    wsel_c    = first_q ? cur_q[STATE_W-1:LOG_PT] : cur_d[STATE_W-1:LOG_PT];
    addr_c    = pt_rd_q ? {stage_q, wsel_c} : '0;
  end

  // Control FSM, read sequencer and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      pt_rd_q     <= 1'b0;
      first_q     <= 1'b0;
      stage_q     <= '0;
      dat_vld_q   <= 1'b0;
      dat_stage_q <= '0;
      cur_q       <= '0;
      blk_q       <= '0;
      out_valid_q <= 1'b0;
      out_bit_q   <= 1'b0;
      out_last_q  <= 1'b0;
`ifdef VDEC_TB_PARALLEL_OUT_EN
      dec_q       <= '0;
`endif
    end else begin
      done_q      <= 1'b0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      case (state_q)
        IDLE: begin
          if (bus.start && !bus.abort) begin
            state_q   <= TRACE;
            busy_q    <= 1'b1;
            pt_rd_q   <= 1'b1;
            first_q   <= 1'b1;
            dat_vld_q <= 1'b0;
            blk_q     <= blk_sat_c;
            stage_q   <= STG_W'(blk_sat_c) + STG_W'(TAIL_LEN - 1);
            cur_q     <= bus.start_state;
`ifdef VDEC_TB_PARALLEL_OUT_EN
            dec_q     <= '0;
`endif
          end
        end
        TRACE: begin
          if (bus.abort) begin
            state_q   <= IDLE;
            busy_q    <= 1'b0;
            pt_rd_q   <= 1'b0;
            first_q   <= 1'b0;
            dat_vld_q <= 1'b0;
          end else begin
            if (pt_rd_q) begin
              first_q <= 1'b0;
              if (stage_q == '0) begin
                pt_rd_q <= 1'b0;
              end else begin
                stage_q <= stage_q - STG_W'(1);
              end
            end
            dat_vld_q   <= pt_rd_q;
            dat_stage_q <= stage_q;
            // Consume the word read last cycle; tail stages are traced silently.
            if (dat_vld_q) begin
              cur_q <= cur_d;
              if (dat_stage_q < STG_W'(blk_q)) begin
                out_valid_q <= 1'b1;
                out_bit_q   <= cur_q[0];
                out_last_q  <= (dat_stage_q == '0);
`ifdef VDEC_TB_PARALLEL_OUT_EN
                dec_q       <= {dec_q[MAX_BLK-2:0], cur_q[0]};
`endif
              end
              if (dat_stage_q == '0) begin
                state_q   <= FIN;
                done_q    <= 1'b1;
                dat_vld_q <= 1'b0;
              end
            end
          end
        end
        FIN: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          pt_rd_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.pt_rd     = pt_rd_q;
  assign bus.pt_addr   = addr_c;
  assign bus.out_valid = out_valid_q;
  assign bus.out_bit   = out_bit_q;
  assign bus.out_last  = out_last_q;
`ifdef VDEC_TB_PARALLEL_OUT_EN
  assign bus.dec_bits  = dec_q;
`endif

  a_done_pulse: assert property (@(posedge clk) disable iff (!rst_n) bus.done |=> !bus.done);
  a_rd_busy:    assert property (@(posedge clk) disable iff (!rst_n) bus.pt_rd |-> bus.busy);
  a_out_busy:   assert property (@(posedge clk) disable iff (!rst_n) bus.out_valid |-> bus.busy);

endmodule

// File: tb/tb_vdec_tb_param.sv
// Directed bench for vdec_tb_param: default instance plus a STATE_W=6 / PT_W=16 instance.
module tb_vdec_tb_param;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  vdec_tb_param_if #(.STATE_W(8), .PT_W(32), .MAX_BLK(29), .TAIL_LEN(8)) bus_a ();
  vdec_tb_param_if #(.STATE_W(6), .PT_W(16), .MAX_BLK(29), .TAIL_LEN(8)) bus_b ();

  vdec_tb_param #(.STATE_W(8), .PT_W(32), .MAX_BLK(29), .TAIL_LEN(8)) u_dut_a (
    .clk(clk), .rst_n(rst_n), .bus(bus_a.slave)
  );
  vdec_tb_param #(.STATE_W(6), .PT_W(16), .MAX_BLK(29), .TAIL_LEN(8)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .bus(bus_b.slave)
  );

  logic [31:0] mem_a [0:511];
  logic [15:0] mem_b [0:255];

  // Survivor RAMs with one cycle read latency.
  always @(posedge clk) if (bus_a.pt_rd) bus_a.pt_dout <= mem_a[bus_a.pt_addr];
  always @(posedge clk) if (bus_b.pt_rd) bus_b.pt_dout <= mem_b[bus_b.pt_addr];

  int checks = 0;
  int errors = 0;
  int done_cnt = 0;
  int viol = 0;

  always @(posedge clk) begin
    if (bus_a.done) done_cnt <= done_cnt + 1;
    if ((bus_a.out_valid || bus_a.done || bus_a.pt_rd) && !bus_a.busy) viol <= viol + 1;
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Forward-encode info bits (u0 first) plus 8 zero tail bits into the survivor RAM.
  task automatic load_enc(input int bl, input logic [28:0] info);
    logic [7:0] s;
    logic [7:0] prev;
    logic u;
    for (int i = 0; i < 512; i++) mem_a[i] = '0;
    s = '0;
    for (int t = 0; t < bl + 8; t++) begin
      u = (t < bl) ? info[t] : 1'b0;
      prev = s;
      s = {s[6:0], u};
      mem_a[t*8 + int'(s[7:5])][31 - int'(s[4:0])] = prev[7];
    end
  endtask

  task automatic run_a(input string tag, input int bl, input logic [7:0] ss, input int exp_n,
                       input int exp_nout, input logic [28:0] exp_stream,
                       input int exp_first_addr, input int restart_at);
    int cyc, rd, nout, last_at, done_cyc, first_addr, bad_order, d0;
    logic [28:0] stream;
    d0 = done_cnt;
    bus_a.start = 1'b1;
    bus_a.blk_len = 5'(bl);
    bus_a.start_state = ss;
    @(negedge clk);
    bus_a.start = 1'b0;
    bus_a.blk_len = 5'd3;
    bus_a.start_state = 8'h5C;
    cyc = 1; rd = 0; nout = 0; last_at = 0; done_cyc = 0; first_addr = -1; bad_order = 0;
    stream = '0;
    while (done_cyc == 0 && cyc < 200) begin
      bus_a.start = (cyc == restart_at);
      if (bus_a.pt_rd) begin
        if (rd == 0) begin
          first_addr = int'(bus_a.pt_addr);
          if (cyc != 1) bad_order++;
        end
        if (int'(bus_a.pt_addr[8:3]) != exp_n - 1 - rd) bad_order++;
        rd++;
      end
      if (bus_a.out_valid) begin
        stream = {stream[27:0], bus_a.out_bit};
        nout++;
        if (bus_a.out_last) last_at = nout;
      end
      if (bus_a.done) done_cyc = cyc;
      @(negedge clk);
      cyc++;
    end
    bus_a.start = 1'b0;
    chk({tag, " reads"}, 64'(rd), 64'(exp_n));
    chk({tag, " first_addr"}, 64'(first_addr), 64'(exp_first_addr));
    chk({tag, " stage_order"}, 64'(bad_order), 64'd0);
    chk({tag, " done_cycle"}, 64'(done_cyc), 64'(exp_n + 2));
    chk({tag, " nout"}, 64'(nout), 64'(exp_nout));
    chk({tag, " stream"}, 64'(stream), 64'(exp_stream));
    chk({tag, " last_pos"}, 64'(last_at), 64'(exp_nout));
    chk({tag, " busy_after"}, 64'(bus_a.busy), 64'd0);
    chk({tag, " done_count"}, 64'(done_cnt - d0), 64'd1);
`ifdef VDEC_TB_PARALLEL_OUT_EN
    chk({tag, " dec_bits"}, 64'(bus_a.dec_bits), 64'(exp_stream));
`endif
  endtask

  initial begin
    int d0, cyc, rd, nout, dc, a0, a1;
    bus_a.start = 1'b0; bus_a.abort = 1'b0; bus_a.blk_len = '0; bus_a.start_state = '0;
    bus_b.start = 1'b0; bus_b.abort = 1'b0; bus_b.blk_len = '0; bus_b.start_state = '0;
    load_enc(0, '0);
    for (int i = 0; i < 256; i++) mem_b[i] = '0;
    #2;
    chk("reset_a", 64'({bus_a.busy, bus_a.done, bus_a.pt_rd, bus_a.pt_addr, bus_a.out_valid,
                        bus_a.out_bit, bus_a.out_last}), 64'd0);
    chk("reset_b", 64'({bus_b.busy, bus_b.done, bus_b.pt_rd, bus_b.pt_addr, bus_b.out_valid,
                        bus_b.out_bit, bus_b.out_last}), 64'd0);
`ifdef VDEC_TB_PARALLEL_OUT_EN
    chk("reset_dec", 64'(bus_a.dec_bits), 64'd0);
`endif
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Start in the cycle right after reset release.
    run_a("zero29", 29, 8'h00, 37, 29, 29'h0, 288, 0);
    load_enc(4, 29'hD);
    run_a("info4", 4, 8'h00, 12, 4, 29'hD, 88, 0);
    load_enc(7, 29'h5A);
    run_a("info7", 7, 8'h00, 15, 7, 29'h5A, 112, 0);
    load_enc(29, 29'h15A5C3E1);
    run_a("info29", 29, 8'h00, 37, 29, 29'h15A5C3E1, 288, 0);
    run_a("sat31", 31, 8'h00, 37, 29, 29'h15A5C3E1, 288, 0);
    load_enc(0, '0);
    run_a("blk0", 0, 8'hA5, 8, 0, 29'h0, 61, 0);
    load_enc(4, 29'hD);
    run_a("restart", 4, 8'h00, 12, 4, 29'hD, 88, 3);

    // start together with abort in IDLE is dropped.
    d0 = done_cnt;
    bus_a.start = 1'b1; bus_a.abort = 1'b1; bus_a.blk_len = 5'd4;
    @(negedge clk);
    bus_a.start = 1'b0; bus_a.abort = 1'b0;
    chk("startabort_busy", 64'(bus_a.busy), 64'd0);
    chk("startabort_rd", 64'(bus_a.pt_rd), 64'd0);
    repeat (20) @(negedge clk);
    chk("startabort_done", 64'(done_cnt - d0), 64'd0);

    // Abort five cycles after start.
    load_enc(0, '0);
    d0 = done_cnt;
    bus_a.start = 1'b1; bus_a.blk_len = 5'd29; bus_a.start_state = 8'h00;
    @(negedge clk);
    bus_a.start = 1'b0;
    repeat (4) @(negedge clk);
    chk("abort_pre_rd", 64'(bus_a.pt_rd), 64'd1);
    bus_a.abort = 1'b1;
    @(negedge clk);
    bus_a.abort = 1'b0;
    chk("abort_rd", 64'(bus_a.pt_rd), 64'd0);
    chk("abort_busy", 64'(bus_a.busy), 64'd0);
    chk("abort_ov", 64'(bus_a.out_valid), 64'd0);
    repeat (45) @(negedge clk);
    chk("abort_nodone", 64'(done_cnt - d0), 64'd0);
    load_enc(4, 29'hD);
    run_a("post_abort", 4, 8'h00, 12, 4, 29'hD, 88, 0);

    // Asynchronous reset while bits are streaming.
    load_enc(29, 29'h15A5C3E1);
    d0 = done_cnt;
    bus_a.start = 1'b1; bus_a.blk_len = 5'd29; bus_a.start_state = 8'h00;
    @(negedge clk);
    bus_a.start = 1'b0;
    repeat (13) @(negedge clk);
    chk("rst_pre_ov", 64'(bus_a.out_valid), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_async", 64'({bus_a.busy, bus_a.done, bus_a.pt_rd, bus_a.pt_addr, bus_a.out_valid,
                          bus_a.out_bit, bus_a.out_last}), 64'd0);
`ifdef VDEC_TB_PARALLEL_OUT_EN
    chk("rst_dec", 64'(bus_a.dec_bits), 64'd0);
`endif
    @(negedge clk);
    rst_n = 1'b1;
    repeat (45) @(negedge clk);
    chk("rst_nodone", 64'(done_cnt - d0), 64'd0);

    // Small instance: word select from start_state, then from the read word.
    bus_b.start = 1'b1; bus_b.blk_len = 5'd0; bus_b.start_state = 6'h2A;
    @(negedge clk);
    bus_b.start = 1'b0;
    cyc = 1; rd = 0; nout = 0; dc = 0; a0 = -1; a1 = -1;
    while (dc == 0 && cyc < 100) begin
      if (bus_b.pt_rd) begin
        if (rd == 0) a0 = int'(bus_b.pt_addr);
        if (rd == 1) a1 = int'(bus_b.pt_addr);
        rd++;
      end
      if (bus_b.out_valid || bus_b.out_last) nout++;
      if (bus_b.done) dc = cyc;
      @(negedge clk);
      cyc++;
    end
    chk("b_reads", 64'(rd), 64'd8);
    chk("b_addr0", 64'(a0), 64'd30);
    chk("b_addr1", 64'(a1), 64'd25);
    chk("b_nout", 64'(nout), 64'd0);
    chk("b_done_cycle", 64'(dc), 64'd10);
    chk("b_busy_after", 64'(bus_b.busy), 64'd0);

    chk("idle_quiet", 64'(viol), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
